// File: rtl/imem_loader.sv
// Streams little-endian bytes into 32-bit instruction RAM words (5 cycles/word best case); s_ready low outside RECV.
// Define IMEM_LOADER_VERIFY_EN to add an XOR-checksum readback pass through the registered RAM read port.
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [10:0]       word_count,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_VERIFY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [10:0]       n_q, n_d;
  logic [10:0]       word_ptr_q, word_ptr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [ADDR_W-1:0] wp_addr;

  always_comb begin
    wp_addr = '0;
    wp_addr[AW-1:0] = word_ptr_q[AW-1:0];
  end

`ifdef IMEM_LOADER_VERIFY_EN
  logic [31:0]       csum_q, csum_d;
  logic [31:0]       rb_sum_q, rb_sum_d;
  logic [10:0]       vptr_q, vptr_d;
  logic [ADDR_W-1:0] vp_addr;

  always_comb begin
    vp_addr = '0;
    vp_addr[AW-1:0] = vptr_q[AW-1:0];
  end
`else
  logic unused_douta;
  assign unused_douta = ^ram_douta;
`endif

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_ptr_d = word_ptr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    error_d    = error_q;
    s_ready    = 1'b0;
    ram_wea    = 4'h0;
    ram_addra  = addr_q;
    ram_dina   = din_q;
`ifdef IMEM_LOADER_VERIFY_EN
    csum_d     = csum_q;
    rb_sum_d   = rb_sum_q;
    vptr_d     = vptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d        = word_count;
          word_ptr_d = '0;
          byte_idx_d = '0;
          error_d    = 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
          csum_d     = '0;
          rb_sum_d   = '0;
          vptr_d     = '0;
`endif
          if (word_count == 11'd0) begin
            state_d = S_DONE;
          end else if ({21'd0, word_count} > 32'(DEPTH)) begin
            state_d = S_DONE;
            error_d = 1'b1;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        s_ready = 1'b1;
        // Abort beats a simultaneous lane-3 byte so no write is launched.
        if (abort) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else if (s_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = s_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_wea    = 4'hF;
        ram_addra  = wp_addr;
        ram_dina   = word_q;
        byte_idx_d = '0;
        word_ptr_d = word_ptr_q + 11'd1;
`ifdef IMEM_LOADER_VERIFY_EN
        csum_d     = csum_q ^ word_q;
`endif
        if (abort) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else if (word_ptr_q + 11'd1 == n_q) begin
`ifdef IMEM_LOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef IMEM_LOADER_VERIFY_EN
      S_VERIFY: begin
        // vptr_q == n_q is the extra cycle that collects the last read.
        if (vptr_q != n_q) begin
          ram_addra = vp_addr;
          vptr_d    = vptr_q + 11'd1;
        end
        if (vptr_q != 11'd0) rb_sum_d = rb_sum_q ^ ram_douta;
        if (abort) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else if (vptr_q == n_q) begin
          state_d = S_DONE;
          error_d = ((rb_sum_q ^ ram_douta) != csum_q);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    addr_d = ram_addra;
    din_d  = ram_dina;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_ptr_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      error_q    <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
      csum_q     <= '0;
      rb_sum_q   <= '0;
      vptr_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_ptr_q <= word_ptr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      error_q    <= error_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
`ifdef IMEM_LOADER_VERIFY_EN
      csum_q     <= csum_d;
      rb_sum_q   <= rb_sum_d;
      vptr_q     <= vptr_d;
`endif
    end
  end

  assign busy     = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_VERIFY);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);
  assign error    = error_q;
endmodule
